// File: rtl/lns_pkg.sv
// Shared LNS word format, range limits and the elaboration-time sb/db table generator.
package lns_pkg;

    localparam int unsigned LOG_W     = 11;
    localparam int unsigned FRAC_W    = 7;
    localparam int          L_MIN     = -1024;
    localparam int          L_MAX     = 1023;
    localparam int unsigned PHI_DEPTH = 2 ** LOG_W;
    localparam int unsigned PHI_SB_W  = FRAC_W + 1;
    localparam int unsigned PHI_DB_W  = LOG_W + 1;

    // Working precision of the table generator: Q30 linear values, 20 fractional log bits
    localparam int unsigned Q_FRAC   = 30;
    localparam int unsigned LOG_BITS = 20;
    localparam logic [63:0] Q_ONE    = 64'd1 << Q_FRAC;

    typedef struct packed {
        logic                    sign;
        logic signed [LOG_W-1:0] log;
    } lns_t;

    function automatic logic [63:0] lns_isqrt(input logic [63:0] a);
        logic [63:0] x;
        logic [63:0] y;
        x = a;
        if (a != 64'd0) begin
            y = (x >> 1) + 64'd1;
            while (y < x) begin
                x = y;
                y = (x + a / x) >> 1;
            end
        end
        return x;
    endfunction

    // 2^(-1/2^frac_w) in Q30, by taking frac_w square roots of one half
    function automatic logic [63:0] lns_step(input int unsigned frac_w);
        logic [63:0] v;
        v = Q_ONE >> 1;
        for (int unsigned i = 0; i < frac_w; i++) begin
            v = lns_isqrt(v << Q_FRAC);
        end
        return v;
    endfunction

    // round(2^frac_w * log2(1 +/- 2^(-d/2^frac_w))), floored at l_min
    function automatic int lns_phi_val(input int unsigned d, input int unsigned frac_w,
                                       input logic [63:0] step, input logic sub,
                                       input int l_min);
        logic [63:0] t;
        logic [63:0] p;
        logic [63:0] y;
        logic [63:0] frac;
        int unsigned q;
        int unsigned r;
        int          ip;
        longint      v;
        int          res;
        q = d >> frac_w;
        r = d & ((32'd1 << frac_w) - 32'd1);
        t = Q_ONE;
        p = step;
        for (int unsigned k = 0; k < frac_w; k++) begin
            if (r[k]) t = (t * p) >> Q_FRAC;
            p = (p * p) >> Q_FRAC;
        end
        t = (q > 62) ? 64'd0 : (t >> q);
        res = l_min;
        if (!sub || (t < Q_ONE)) begin
            y = sub ? (Q_ONE - t) : (Q_ONE + t);
            ip = 0;
            while (y < Q_ONE) begin
                y = y << 1;
                ip--;
            end
            while (y >= (Q_ONE << 1)) begin
                y = y >> 1;
                ip++;
            end
            frac = 64'd0;
            for (int k = 0; k < int'(LOG_BITS); k++) begin
                y    = (y * y) >> Q_FRAC;
                frac = frac << 1;
                if (y >= (Q_ONE << 1)) begin
                    y    = y >> 1;
                    frac = frac | 64'd1;
                end
            end
            v   = (longint'(ip) <<< LOG_BITS) + longint'(frac);
            res = int'((v + (longint'(1) <<< (LOG_BITS - frac_w - 1))) >>> (LOG_BITS - frac_w));
            if (res < l_min) res = l_min;
        end
        return res;
    endfunction

endpackage

// File: rtl/lns_phi.sv
// Combinational sb/db evaluator: full-depth ROMs over d, contents generated at elaboration.
module lns_phi #(
    parameter int unsigned LOG_W  = 11,
    parameter int unsigned FRAC_W = 7
) (
    input  logic [LOG_W:0]        i_d,
    input  logic                  i_sub,
    output logic signed [LOG_W:0] o_phi_c
);
    import lns_pkg::*;

    localparam int unsigned DEPTH     = 2 ** LOG_W;
    localparam int          PHI_FLOOR = -(2 ** (LOG_W - 1));
    localparam logic [63:0] STEP      = lns_step(FRAC_W);

    logic [FRAC_W:0]       w_sb_rom [DEPTH];
    logic signed [LOG_W:0] w_db_rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam int SB_V = lns_phi_val(gi, FRAC_W, STEP, 1'b0, PHI_FLOOR);
        localparam int DB_V = lns_phi_val(gi, FRAC_W, STEP, 1'b1, PHI_FLOOR);
        assign w_sb_rom[gi] = (FRAC_W + 1)'(SB_V);
        assign w_db_rom[gi] = (LOG_W + 1)'(DB_V);
    end

    // d never exceeds 2^LOG_W-1; the top bit only guards the lookup
    always_comb begin
        o_phi_c = '0;
        if (!i_d[LOG_W]) begin
            if (i_sub) o_phi_c = w_db_rom[i_d[LOG_W-1:0]];
            else       o_phi_c = (LOG_W + 1)'({1'b0, w_sb_rom[i_d[LOG_W-1:0]]});
        end
    end

endmodule

// File: rtl/adder.sv
// LNS adder: compare/swap, sb/db correction, saturation and a single output register.
module adder #(
    parameter int unsigned LOG_W  = lns_pkg::LOG_W,
    parameter int unsigned FRAC_W = lns_pkg::FRAC_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    input  logic [LOG_W:0] x,
    input  logic [LOG_W:0] y,
    output logic [LOG_W:0] out,
    output logic           out_valid
);
    import lns_pkg::*;

    localparam logic signed [LOG_W+1:0] SAT_HI = (LOG_W + 2)'(L_MAX);
    localparam logic signed [LOG_W+1:0] SAT_LO = (LOG_W + 2)'(L_MIN);

    lns_t                    w_x;
    lns_t                    w_y;
    lns_t                    w_res;
    logic signed [LOG_W:0]   w_xl;
    logic signed [LOG_W:0]   w_yl;
    logic signed [LOG_W:0]   w_lmax;
    logic signed [LOG_W:0]   w_lmin;
    logic signed [LOG_W:0]   w_phi;
    logic [LOG_W:0]          w_d;
    logic                    w_x_dom;
    logic                    w_sub;
    logic                    w_sign;
    logic signed [LOG_W+1:0] w_sum;
    lns_t                    r_out;
    logic                    r_out_valid;

    assign w_x  = x;
    assign w_y  = y;
    assign w_xl = (LOG_W + 1)'(w_x.log);
    assign w_yl = (LOG_W + 1)'(w_y.log);

    // x wins ties so equal-magnitude operands keep a defined dominant sign
    assign w_x_dom = (w_xl >= w_yl);
    assign w_lmax  = w_x_dom ? w_xl : w_yl;
    assign w_lmin  = w_x_dom ? w_yl : w_xl;
    assign w_sign  = w_x_dom ? w_x.sign : w_y.sign;
    assign w_sub   = w_x.sign ^ w_y.sign;
    assign w_d     = w_lmax - w_lmin;

    lns_phi #(
        .LOG_W  (LOG_W),
        .FRAC_W (FRAC_W)
    ) u_phi (
        .i_d     (w_d),
        .i_sub   (w_sub),
        .o_phi_c (w_phi)
    );

    assign w_sum = (LOG_W + 2)'(w_lmax) + (LOG_W + 2)'(w_phi);

    // Exact cancellation maps to the smallest positive code
    always_comb begin
        w_res      = '0;
        w_res.sign = w_sign;
        if (w_sub && (w_d == '0)) begin
            w_res.sign = 1'b0;
            w_res.log  = SAT_LO[LOG_W-1:0];
        end else if (w_sum > SAT_HI) begin
            w_res.log = SAT_HI[LOG_W-1:0];
        end else if (w_sum < SAT_LO) begin
            w_res.log = SAT_LO[LOG_W-1:0];
        end else begin
            w_res.log = w_sum[LOG_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) r_out <= w_res;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder.sv
// Bench for the LNS adder: directed vector table, hold/reset sequences, random stream vs real model.
module tb_adder;
    import lns_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [LOG_W:0] x;
    logic [LOG_W:0] y;
    logic [LOG_W:0] out;
    logic           out_valid;
    int             n_total = 0;
    int             n_bad   = 0;

    adder #(
        .LOG_W  (LOG_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic xs;
        int   xl;
        logic ys;
        int   yl;
        logic es;
        int   el;
        int   tol;
    } vec_t;

    localparam int NV = 16;

    function automatic logic [LOG_W:0] pack_op(input logic s, input int l);
        lns_t p;
        p.sign = s;
        p.log  = LOG_W'(l);
        return p;
    endfunction

    function automatic int clamp_l(input int l);
        if (l > L_MAX) return L_MAX;
        if (l < L_MIN) return L_MIN;
        return l;
    endfunction

    // Real-valued sum of the two decoded operands, re-encoded with range clamping
    function automatic void ref_sum(input logic xs, input int xl, input logic ys, input int yl,
                                    output logic es, output int el);
        real scale;
        real vx;
        real vy;
        real s;
        real lg;
        scale = real'(2 ** FRAC_W);
        vx = $pow(2.0, real'(xl) / scale);
        vy = $pow(2.0, real'(yl) / scale);
        if (xs) vx = -vx;
        if (ys) vy = -vy;
        s  = vx + vy;
        es = 1'b0;
        el = L_MIN;
        if (s != 0.0) begin
            es = (s < 0.0);
            if (s < 0.0) s = -s;
            lg = $ln(s) / $ln(2.0) * scale;
            if (lg > real'(L_MAX)) lg = real'(L_MAX);
            if (lg < real'(L_MIN)) lg = real'(L_MIN);
            el = $rtoi($floor(lg + 0.5));
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input logic es, input int el,
                         input int tol);
        lns_t o;
        int   ol;
        o  = out;
        ol = int'(o.log);
        n_total++;
        if ((out_valid !== ev) || (o.sign !== es) || (ol > el + tol) || (ol < el - tol)) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b sign=%0b log=%0d, want valid=%0b sign=%0b log=%0d (+/-%0d)",
                     name, out_valid, o.sign, ol, ev, es, el, tol);
        end
    endtask

    initial begin
        vec_t vecs[NV];
        logic exp_v;
        logic exp_s;
        int   exp_l;
        int   exp_tol;

        vecs[0]  = '{1'b0,     0, 1'b0,     0, 1'b0,   128, 0};
        vecs[1]  = '{1'b0,   128, 1'b1,     0, 1'b0,     0, 1};
        vecs[2]  = '{1'b1,     0, 1'b0,   128, 1'b0,     0, 1};
        vecs[3]  = '{1'b0,   300, 1'b1,   300, 1'b0, -1024, 0};
        vecs[4]  = '{1'b1,   300, 1'b0,   300, 1'b0, -1024, 0};
        vecs[5]  = '{1'b1,  1023, 1'b1,  1023, 1'b1,  1023, 0};
        vecs[6]  = '{1'b0,     0, 1'b0, -1024, 1'b0,     1, 1};
        vecs[7]  = '{1'b1,     0, 1'b0, -1024, 1'b1,    -1, 1};
        vecs[8]  = '{1'b0, -1024, 1'b0,     0, 1'b0,     1, 1};
        vecs[9]  = '{1'b0, -1024, 1'b1, -1023, 1'b1, -1024, 0};
        vecs[10] = '{1'b0,  1023, 1'b1,  1022, 1'b0,    59, 1};
        vecs[11] = '{1'b0, -1024, 1'b0, -1024, 1'b0,  -896, 0};
        vecs[12] = '{1'b0,  1023, 1'b0, -1024, 1'b0,  1023, 0};
        vecs[13] = '{1'b1,    -5, 1'b0,    -5, 1'b0, -1024, 0};
        vecs[14] = '{1'b0,    36, 1'b0,   100, 1'b0,   199, 1};
        vecs[15] = '{1'b1,   100, 1'b0,    36, 1'b1,  -127, 1};

        rst_n    = 1'b0;
        in_valid = 1'b1;
        x        = pack_op(1'b1, 500);
        y        = pack_op(1'b0, 77);
        tick();
        tick();
        check("reset", 1'b0, 1'b0, 0, 0);

        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            x        = pack_op(vecs[i].xs, vecs[i].xl);
            y        = pack_op(vecs[i].ys, vecs[i].yl);
            tick();
            check($sformatf("vec%0d", i), 1'b1, vecs[i].es, vecs[i].el, vecs[i].tol);
        end

        // Idle cycles with changing operands must leave the last result in place
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b0;
            x        = pack_op(1'b1, 17 * i + 3);
            y        = pack_op(1'b0, -400);
            tick();
            check("hold", 1'b0, vecs[NV-1].es, vecs[NV-1].el, vecs[NV-1].tol);
        end

        exp_s   = vecs[NV-1].es;
        exp_l   = vecs[NV-1].el;
        exp_tol = 1;
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic xs;
            logic ys;
            int   xl;
            int   yl;

            if (i == 1500) begin
                in_valid = 1'b1;
                x        = pack_op(1'b0, 0);
                y        = pack_op(1'b0, 0);
                rst_n    = 1'b0;
                tick();
                check("rst_mid", 1'b0, 1'b0, 0, 0);
                rst_n    = 1'b1;
                in_valid = 1'b0;
                tick();
                check("rst_idle", 1'b0, 1'b0, 0, 0);
                exp_s = 1'b0;
                exp_l = 0;
            end

            v  = ($urandom_range(0, 7) != 0) || (i == 1500);
            xs = 1'($urandom_range(0, 1));
            ys = 1'($urandom_range(0, 1));
            xl = int'($urandom_range(0, 2047)) + L_MIN;
            if ($urandom_range(0, 1) == 0) yl = clamp_l(xl + int'($urandom_range(0, 400)) - 200);
            else                           yl = int'($urandom_range(0, 2047)) + L_MIN;

            in_valid = v;
            x        = pack_op(xs, xl);
            y        = pack_op(ys, yl);
            if (v) ref_sum(xs, xl, ys, yl, exp_s, exp_l);
            exp_v = v;
            tick();
            check("rand", exp_v, exp_s, exp_l, exp_tol);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
